// File: rtl/beep_pkg.sv
// Shared types and default constants for the beep pattern generator.
// The BEEP_PENDING_EN macro (see beep_gen) adds a one-entry request queue.
package beep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_TONE_DIV = 25000;
  localparam int DEF_ON_CYC   = 5000000;
  localparam int DEF_GAP_CYC  = 5000000;
  localparam int DEF_CNT_W    = 24;

  localparam int NB_W = 3;

endpackage

// File: rtl/beep_tone_div.sv
// Loadable tone divider: phase starts high on load, toggles every TONE_DIV
// cycles while running, and is forced low whenever idle.
module beep_tone_div #(
  parameter int TONE_DIV = 25000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic phase_o
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TONE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (load_i) begin
      cnt_d   = RELOAD;
      phase_d = 1'b1;
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_d   = RELOAD;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/beep_gen.sv
// Turns a one-cycle request into 1..7 tone bursts separated by silent gaps.
// Optional BEEP_PENDING_EN: holds one request that arrives while busy.
module beep_gen
  import beep_pkg::*;
#(
  parameter int TONE_DIV = DEF_TONE_DIV,
  parameter int ON_CYC   = DEF_ON_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req,
  input  logic [NB_W-1:0] n_beeps,
  output logic            buzzer,
  output logic            busy,
  output logic            done
);

  localparam logic [CNT_W-1:0] ON_RELOAD  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_RELOAD = CNT_W'(GAP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [NB_W-1:0]  rem_q, rem_d;
  logic             busy_q, done_q, done_d;
  logic             tone_load, tone_run;
  logic             req_start;

`ifdef BEEP_PENDING_EN
  logic             pend_valid_q, pend_valid_d;
  logic [NB_W-1:0]  pend_cnt_q, pend_cnt_d;
`endif

  assign req_start = req && (n_beeps != '0);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rem_d     = rem_q;
    done_d    = 1'b0;
    tone_load = 1'b0;
    tone_run  = 1'b0;
`ifdef BEEP_PENDING_EN
    pend_valid_d = pend_valid_q;
    pend_cnt_d   = pend_cnt_q;
    // Captured before the completion check so a request in the last ON cycle still chains.
    if (state_q != ST_IDLE && req_start) begin
      pend_valid_d = 1'b1;
      pend_cnt_d   = n_beeps;
    end
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_start) begin
          rem_d     = n_beeps;
          timer_d   = ON_RELOAD;
          tone_load = 1'b1;
          state_d   = ST_ON;
        end
      end
      ST_ON: begin
        if (timer_q != '0) begin
          timer_d  = timer_q - CNT_W'(1);
          tone_run = 1'b1;
        end else if (rem_q > NB_W'(1)) begin
          rem_d   = rem_q - NB_W'(1);
          timer_d = GAP_RELOAD;
          state_d = ST_GAP;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          rem_d   = '0;
`ifdef BEEP_PENDING_EN
          if (pend_valid_d) begin
            rem_d        = pend_cnt_d;
            timer_d      = GAP_RELOAD;
            state_d      = ST_GAP;
            pend_valid_d = 1'b0;
          end
`endif
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          timer_d   = ON_RELOAD;
          tone_load = 1'b1;
          state_d   = ST_ON;
        end else begin
          timer_d = timer_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
    end
  end

`ifdef BEEP_PENDING_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_cnt_q   <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_cnt_q   <= pend_cnt_d;
    end
  end
`endif

  beep_tone_div #(
    .TONE_DIV(TONE_DIV),
    .CNT_W   (CNT_W)
  ) u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (tone_load),
    .run_i  (tone_run),
    .phase_o(buzzer)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_beep_gen.sv
// Self-checking bench for beep_gen: vector table, hand sequences and random
// traffic against a pattern-timeline reference model.
module tb_beep_gen;

  localparam int TD  = 2;
  localparam int ONC = 8;
  localparam int GPC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic [2:0] n_beeps = 3'd0;
  logic       buzzer, busy, done;

  beep_gen #(
    .TONE_DIV(TD),
    .ON_CYC  (ONC),
    .GAP_CYC (GPC),
    .CNT_W   (24)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .n_beeps(n_beeps),
    .buzzer (buzzer),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pattern is a timeline of n bursts and n-1 gaps; the
  // offset into that timeline alone determines buzzer and busy.
  int m_active = 0, m_off = 0, m_len = 0, m_done = 0;
  int m_pv = 0, m_pn = 0;

  function automatic int pat_len(input int n);
    return n * ONC + (n - 1) * GPC;
  endfunction

  function automatic int exp_buz();
    int p;
    if (m_active == 0) return 0;
    p = m_off % (ONC + GPC);
    if (p >= ONC) return 0;
    return ((p / TD) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic model_step(input int r, input int q, input int n);
    int dn;
    dn = 0;
    if (r == 0) begin
      m_active = 0; m_pv = 0;
    end else if (m_active != 0) begin
`ifdef BEEP_PENDING_EN
      if (q != 0 && n != 0) begin m_pv = 1; m_pn = n; end
`endif
      if (m_off == m_len - 1) begin
        dn = 1;
        if (m_pv != 0) begin
          // Chained pattern = one already-played burst followed by the new ones.
          m_len = pat_len(m_pn + 1);
          m_off = ONC;
          m_pv  = 0;
        end else begin
          m_active = 0;
        end
      end else begin
        m_off++;
      end
    end else if (q != 0 && n != 0) begin
      m_active = 1; m_off = 0; m_len = pat_len(n);
    end
    m_done = dn;
  endtask

  task automatic do_cycle(input int r, input int q, input int n);
    rst_n = r[0]; req = q[0]; n_beeps = 3'(n);
    @(posedge clk);
    model_step(r, q, n);
    #1;
    chk("model_busy", int'(busy), m_active);
    chk("model_buzzer", int'(buzzer), exp_buz());
    chk("model_done", int'(done), m_done);
  endtask

  typedef struct {
    logic       req;
    logic [2:0] n;
    logic       busy;
    logic       buzzer;
    logic       done;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic q, input logic [2:0] n,
                              input logic b, input logic z, input logic d);
    vec_t v;
    v.req = q; v.n = n; v.busy = b; v.buzzer = z; v.done = d;
    return v;
  endfunction

  initial begin
    int c, busy_cnt, done_cnt, done_at;

    // Each row: inputs during one cycle, outputs expected in the following cycle.
    tbl[0]  = mk(1, 1, 1, 1, 0);
    tbl[1]  = mk(0, 0, 1, 1, 0);
    tbl[2]  = mk(0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 0, 1, 1, 0);
    tbl[5]  = mk(0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0, 1);
    tbl[9]  = mk(0, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 1, 1, 0);
    tbl[13] = mk(0, 0, 1, 1, 0);
    tbl[14] = mk(0, 0, 1, 0, 0);
    tbl[15] = mk(0, 0, 1, 0, 0);
    tbl[16] = mk(0, 0, 1, 1, 0);
    tbl[17] = mk(0, 0, 1, 1, 0);
    tbl[18] = mk(0, 0, 1, 0, 0);
    tbl[19] = mk(0, 0, 1, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 1);
    tbl[21] = mk(1, 2, 1, 1, 0);

    // Reset, with a request that must be ignored.
    do_cycle(0, 0, 0);
    do_cycle(0, 1, 3);
    chk("reset_busy", int'(busy), 0);
    chk("reset_buzzer", int'(buzzer), 0);
    chk("reset_done", int'(done), 0);
    do_cycle(1, 0, 0);

    for (int i = 0; i < 22; i++) begin
      do_cycle(1, int'(tbl[i].req), int'(tbl[i].n));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("vec%0d_buzzer", i), int'(buzzer), int'(tbl[i].buzzer));
      chk($sformatf("vec%0d_done", i), int'(done), int'(tbl[i].done));
    end
    repeat (30) do_cycle(1, 0, 0);

    // Triple beep: busy cycles 1..32, done at 33.
    do_cycle(1, 1, 3);
    c = 1; busy_cnt = 0; done_cnt = 0; done_at = 0;
    repeat (40) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = c; end
      if (c >= 9 && c <= 12) chk("triple_gap_buzzer", int'(buzzer), 0);
      do_cycle(1, 0, 0);
      c++;
    end
    chk("triple_busy_cycles", busy_cnt, 32);
    chk("triple_done_count", done_cnt, 1);
    chk("triple_done_cycle", done_at, 33);

    // Request while busy.
    do_cycle(1, 1, 1);
    c = 1; busy_cnt = 0; done_cnt = 0; done_at = 0;
    repeat (44) begin
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_at = c; end
      if (c == 4) do_cycle(1, 1, 2);
      else        do_cycle(1, 0, 0);
      c++;
    end
`ifdef BEEP_PENDING_EN
    chk("busyreq_busy_cycles", busy_cnt, 32);
    chk("busyreq_done_count", done_cnt, 2);
    chk("busyreq_last_done", done_at, 33);
`else
    chk("busyreq_busy_cycles", busy_cnt, 8);
    chk("busyreq_done_count", done_cnt, 1);
    chk("busyreq_last_done", done_at, 9);
`endif

    // Reset mid-burst: low during cycle 5, everything clear in cycle 6.
    do_cycle(1, 1, 3);
    repeat (4) do_cycle(1, 0, 0);
    do_cycle(0, 0, 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_buzzer", int'(buzzer), 0);
    chk("midrst_done", int'(done), 0);
    do_cycle(1, 0, 0);
    do_cycle(1, 1, 1);
    chk("postrst_busy", int'(busy), 1);
    chk("postrst_buzzer", int'(buzzer), 1);
    repeat (12) do_cycle(1, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      int r, q, n;
      r = ($urandom_range(0, 199) == 0) ? 0 : 1;
      q = ($urandom_range(0, 9) == 0) ? 1 : 0;
      n = int'($urandom_range(0, 7));
      do_cycle(r, q, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
